// File: rtl/sachen_gen_pkg.sv
// Shared constants for the generic Sachen mapper: register indices, mirroring
// modes and the A12 low-time filter length.
package sachen_gen_pkg;

  localparam logic [3:0] REG_PRG    = 4'd8;
  localparam logic [3:0] REG_MIRROR = 4'd9;
  localparam logic [3:0] REG_LATCH  = 4'd10;
  localparam logic [3:0] REG_IRQEN  = 4'd11;
  localparam logic [3:0] REG_RELOAD = 4'd12;
  localparam logic [3:0] REG_ACK    = 4'd13;

  localparam int A12_FILT = 3;

  // Only A15, A14, A8 and A0 take part in register decoding.
  localparam logic [15:0] ADDR_MASK = 16'hC101;
  localparam logic [15:0] ADDR_IDX  = 16'h4100;
  localparam logic [15:0] ADDR_DATA = 16'h4101;

  typedef enum logic [1:0] {
    MIR_VERT = 2'd0,
    MIR_HORZ = 2'd1,
    MIR_ZERO = 2'd2,
    MIR_ONE  = 2'd3
  } mirror_e;

  function automatic logic addr_is(input logic [15:0] a, input logic [15:0] match);
    return (a & ADDR_MASK) == match;
  endfunction

endpackage

// File: rtl/sachen_irq_a12.sv
// Scanline IRQ: filtered PPU A12 rising-edge counter with latch, reload and
// pending flag.
module sachen_irq_a12 import sachen_gen_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       a12_i,
  input  logic       wr_latch_i,
  input  logic       wr_en_i,
  input  logic       wr_reload_i,
  input  logic       wr_ack_i,
  input  logic [7:0] din_i,
  output logic       irq_o
);

  localparam int FW = $clog2(A12_FILT + 1);

  logic [7:0]    latch_q;
  logic [7:0]    counter_q;
  logic [7:0]    counter_d;
  logic          en_q;
  logic          pending_q;
  logic          reload_q;
  logic          a12_q;
  logic [FW-1:0] low_cnt_q;
  logic          count;
  logic          reload_clr;

  // An edge counts only after A12 sat low for A12_FILT CPU cycles.
  assign count = a12_i & ~a12_q & (low_cnt_q == FW'(A12_FILT));

  always_comb begin
    counter_d  = counter_q - 8'd1;
    reload_clr = 1'b0;
    if (counter_q == 8'd0 || reload_q) begin
      counter_d  = latch_q;
      reload_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      en_q      <= 1'b0;
      pending_q <= 1'b0;
      reload_q  <= 1'b0;
      a12_q     <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      a12_q <= a12_i;
      if (a12_i) begin
        low_cnt_q <= '0;
      end else if (ce && low_cnt_q != FW'(A12_FILT)) begin
        low_cnt_q <= low_cnt_q + FW'(1);
      end
      if (wr_latch_i) latch_q <= din_i;
      if (wr_en_i) en_q <= din_i[0];
      if ((wr_en_i && !din_i[0]) || wr_ack_i) pending_q <= 1'b0;
      if (count) begin
        counter_q <= counter_d;
        if (reload_clr) reload_q <= 1'b0;
        // Later assignment wins: a counted edge beats a same-cycle ack/disable.
        if (counter_d == 8'd0 && en_q) pending_q <= 1'b1;
      end
      if (wr_reload_i) reload_q <= 1'b1;
    end
  end

  assign irq_o = pending_q;

endmodule

// File: rtl/sachen_mapper_gen.sv
// Generic Sachen 8259-style mapper: indexed register file at $4100/$4101,
// PRG/CHR banking, mirroring, protection readback and A12 scanline IRQ.
module sachen_mapper_gen import sachen_gen_pkg::*; #(
  parameter int NCHR   = 4,
  parameter int BW     = 3,
  parameter int IRQ_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        enable,
  input  logic [31:0] flags,
  input  logic [15:0] prg_ain,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [7:0]  prg_din,
  input  logic [13:0] chr_ain,
  inout  wire  [21:0] prg_aout_b,
  inout  wire  [7:0]  prg_dout_b,
  inout  wire         prg_allow_b,
  inout  wire  [21:0] chr_aout_b,
  inout  wire         chr_allow_b,
  inout  wire         vram_a10_b,
  inout  wire         vram_ce_b,
  inout  wire         irq_b,
  inout  wire  [15:0] flags_out_b
);

  localparam int         SLOT_W  = (NCHR == 8) ? 3 : 2;
  localparam int         OFF_W   = 13 - SLOT_W;
  localparam int         BANK_FW = 20 - OFF_W;
  localparam logic [3:0] NCHR_L  = 4'(NCHR);

  logic [3:0]        idx_q;
  logic [BW-1:0]     chr_bank_q [NCHR];
  logic [BW-1:0]     prg_bank_q;
  mirror_e           mirror_q;
  logic              tog_q;
  logic              idx_hit;
  logic              idx_wr;
  logic              data_wr;
  logic [SLOT_W-1:0] slot;
  logic              vram_a10;
  logic              irq;
  logic              unused_flags;

  assign idx_hit = addr_is(prg_ain, ADDR_IDX);
  assign idx_wr  = ce & prg_write & idx_hit;
  assign data_wr = ce & prg_write & addr_is(prg_ain, ADDR_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 4'd0;
      prg_bank_q <= '0;
      mirror_q   <= MIR_VERT;
      tog_q      <= 1'b0;
      for (int n = 0; n < NCHR; n++) chr_bank_q[n] <= BW'(n);
    end else begin
      if (idx_wr) idx_q <= prg_din[3:0];
      if (ce && prg_read && idx_hit) tog_q <= ~tog_q;
      if (data_wr) begin
        if (idx_q < NCHR_L) chr_bank_q[idx_q[SLOT_W-1:0]] <= prg_din[BW-1:0];
        else if (idx_q == REG_PRG) prg_bank_q <= prg_din[BW-1:0];
        else if (idx_q == REG_MIRROR) mirror_q <= mirror_e'(prg_din[1:0]);
      end
    end
  end

  generate
    if (IRQ_EN != 0) begin : g_irq
      sachen_irq_a12 u_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .a12_i       (chr_ain[12]),
        .wr_latch_i  (data_wr && idx_q == REG_LATCH),
        .wr_en_i     (data_wr && idx_q == REG_IRQEN),
        .wr_reload_i (data_wr && idx_q == REG_RELOAD),
        .wr_ack_i    (data_wr && idx_q == REG_ACK),
        .din_i       (prg_din),
        .irq_o       (irq)
      );
    end else begin : g_no_irq
      assign irq = 1'b0;
    end
  endgenerate

  assign slot = chr_ain[OFF_W +: SLOT_W];

  always_comb begin
    vram_a10 = 1'b0;
    case (mirror_q)
      MIR_VERT: vram_a10 = chr_ain[10];
      MIR_HORZ: vram_a10 = chr_ain[11];
      MIR_ZERO: vram_a10 = 1'b0;
      MIR_ONE:  vram_a10 = 1'b1;
      default:  vram_a10 = 1'b0;
    endcase
  end

  assign unused_flags = ^{flags[31:16], flags[14:0]};

  assign prg_aout_b  = enable ? 22'({prg_bank_q, prg_ain[14:0]}) : 22'bz;
  assign prg_dout_b  = enable ? {3'b001, tog_q, ~idx_q} : 8'bz;
  assign prg_allow_b = enable ? (prg_ain[15] & ~prg_write) : 1'bz;
  assign chr_aout_b  = enable ? {2'b10, BANK_FW'(chr_bank_q[slot]), chr_ain[OFF_W-1:0]} : 22'bz;
  assign chr_allow_b = enable ? flags[15] : 1'bz;
  assign vram_a10_b  = enable ? vram_a10 : 1'bz;
  assign vram_ce_b   = enable ? chr_ain[13] : 1'bz;
  assign irq_b       = enable ? irq : 1'bz;
  assign flags_out_b = enable ? {12'd0, 1'b1, 1'b0, idx_hit, 1'b0} : 16'bz;

endmodule

// File: tb/tb_sachen_mapper_gen.sv
// Bench for sachen_mapper_gen (default parameters): directed tables, corner
// sequences and a randomized run against an arithmetic reference model.
module tb_sachen_mapper_gen;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        enable;
  logic [31:0] flags;
  logic [15:0] prg_ain;
  logic        prg_read;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [13:0] chr_ain;
  wire  [21:0] prg_aout_b;
  wire  [7:0]  prg_dout_b;
  wire         prg_allow_b;
  wire  [21:0] chr_aout_b;
  wire         chr_allow_b;
  wire         vram_a10_b;
  wire         vram_ce_b;
  wire         irq_b;
  wire  [15:0] flags_out_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  sachen_mapper_gen dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable), .flags(flags),
    .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write), .prg_din(prg_din),
    .chr_ain(chr_ain), .prg_aout_b(prg_aout_b), .prg_dout_b(prg_dout_b),
    .prg_allow_b(prg_allow_b), .chr_aout_b(chr_aout_b), .chr_allow_b(chr_allow_b),
    .vram_a10_b(vram_a10_b), .vram_ce_b(vram_ce_b), .irq_b(irq_b), .flags_out_b(flags_out_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_bank[4];
  int m_prg, m_mir, m_idx, m_tog, m_latch, m_cnt, m_en, m_pend, m_rel, m_a12, m_low;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) m_bank[n] = n;
    m_prg = 0; m_mir = 0; m_idx = 0; m_tog = 0; m_latch = 0; m_cnt = 0;
    m_en = 0; m_pend = 0; m_rel = 0; m_a12 = 0; m_low = 0;
  endtask

  task automatic model_step();
    int a, d, new_cnt, a12;
    bit wr, hit_i, hit_d, counted, set_p, rel_clr, rel_set;
    a = int'(prg_ain);
    d = int'(prg_din);
    wr = ce && prg_write;
    hit_i = (a & 'hC101) == 'h4100;
    hit_d = (a & 'hC101) == 'h4101;
    a12 = (int'(chr_ain) / 4096) % 2;
    counted = (a12 == 1) && (m_a12 == 0) && (m_low >= 3);
    set_p = 0; rel_clr = 0; rel_set = 0; new_cnt = m_cnt;
    if (counted) begin
      if (m_cnt == 0 || m_rel != 0) begin
        new_cnt = m_latch;
        rel_clr = 1;
      end else begin
        new_cnt = m_cnt - 1;
      end
      set_p = (new_cnt == 0) && (m_en != 0);
    end
    if (wr && hit_d) begin
      if (m_idx < 4) m_bank[m_idx] = d % 8;
      else case (m_idx)
        8:  m_prg = d % 8;
        9:  m_mir = d % 4;
        10: m_latch = d;
        11: begin m_en = d % 2; if (d % 2 == 0) m_pend = 0; end
        12: rel_set = 1;
        13: m_pend = 0;
        default: ;
      endcase
    end
    if (rel_clr) m_rel = 0;
    if (rel_set) m_rel = 1;
    if (set_p) m_pend = 1;
    m_cnt = new_cnt;
    if (a12 == 1) m_low = 0;
    else if (ce) m_low = m_low + 1;
    m_a12 = a12;
    if (wr && hit_i) m_idx = d % 16;
    if (ce && prg_read && hit_i) m_tog = 1 - m_tog;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    prg_ain = addr; prg_din = data; prg_write = 1'b1; ce = 1'b1;
    tick();
    prg_write = 1'b0; ce = 1'b0;
  endtask

  task automatic a12_pulse(input int low_ces, input int idle_clks);
    chr_ain = 14'h0000; ce = 1'b1;
    repeat (low_ces) tick();
    ce = 1'b0;
    repeat (idle_clks) tick();
    chr_ain = 14'h1000;
    tick();
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    int a, c, a10;
    a = int'(prg_ain);
    c = int'(chr_ain);
    case (m_mir)
      0: a10 = (c / 1024) % 2;
      1: a10 = (c / 2048) % 2;
      2: a10 = 0;
      default: a10 = 1;
    endcase
    chk("prg_aout", 32'(prg_aout_b), 32'(m_prg * 32768 + a % 32768));
    chk("prg_dout", 32'(prg_dout_b), 32'(32 + m_tog * 16 + (15 - m_idx)));
    chk("prg_allow", 32'(prg_allow_b), 32'(((a / 32768) % 2) & (prg_write ? 0 : 1)));
    chk("chr_aout", 32'(chr_aout_b), 32'('h200000 + m_bank[(c / 2048) % 4] * 2048 + c % 2048));
    chk("chr_allow", 32'(chr_allow_b), 32'((flags / 32768) % 2));
    chk("vram_a10", 32'(vram_a10_b), 32'(a10));
    chk("vram_ce", 32'(vram_ce_b), 32'((c / 8192) % 2));
    chk("irq", 32'(irq_b), 32'(m_pend));
    chk("flags_out", 32'(flags_out_b), 32'(8 + (((a & 'hC101) == 'h4100) ? 2 : 0)));
  endtask

  typedef struct {
    logic [13:0] chr;
    logic [7:0]  mir;
    logic [21:0] exp_chr;
    logic        exp_a10;
    logic        exp_ce;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic a12_lvl;
    tbl[0] = '{14'h0000, 8'd0, 22'h200000, 1'b0, 1'b0};
    tbl[1] = '{14'h0C05, 8'd0, 22'h200C05, 1'b1, 1'b0};
    tbl[2] = '{14'h2C05, 8'd1, 22'h200C05, 1'b1, 1'b1};
    tbl[3] = '{14'h1400, 8'd1, 22'h201400, 1'b0, 1'b0};
    tbl[4] = '{14'h1FFF, 8'd2, 22'h201FFF, 1'b0, 1'b0};
    tbl[5] = '{14'h3800, 8'd3, 22'h201800, 1'b1, 1'b1};

    rst_n = 1'b0; ce = 1'b0; enable = 1'b1; flags = 32'h0000_8000;
    prg_ain = 16'h4100; prg_read = 1'b0; prg_write = 1'b0; prg_din = 8'h00;
    chr_ain = 14'h0800;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_prg_dout", 32'(prg_dout_b), 32'h2F);
    chk("rst_flags_out", 32'(flags_out_b), 32'hA);
    chk("rst_chr_aout", 32'(chr_aout_b), 32'h200800);
    chk("rst_prg_aout", 32'(prg_aout_b), 32'h004100);
    chk("rst_vram_a10", 32'(vram_a10_b), 32'h0);
    chk("rst_irq", 32'(irq_b), 32'h0);
    chk("rst_chr_allow", 32'(chr_allow_b), 32'h1);
    chk("rst_prg_allow", 32'(prg_allow_b), 32'h0);

    // protection readback toggles on each read of the index port
    wr(16'h4100, 8'h03);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h2C); exp_q.push_back(8'h3C);
    for (int i = 0; i < 3; i++) begin
      prg_ain = 16'h4100; prg_read = 1'b1; ce = 1'b1;
      tick();
      prg_read = 1'b0; ce = 1'b0;
      chk("tog_read", 32'(prg_dout_b), 32'(exp_q.pop_front()));
    end

    // CHR slot / mirroring table
    foreach (tbl[i]) begin
      wr(16'h4100, 8'd9);
      wr(16'h4101, tbl[i].mir);
      chr_ain = tbl[i].chr;
      #1;
      chk("tbl_chr_aout", 32'(chr_aout_b), 32'(tbl[i].exp_chr));
      chk("tbl_vram_a10", 32'(vram_a10_b), 32'(tbl[i].exp_a10));
      chk("tbl_vram_ce", 32'(vram_ce_b), 32'(tbl[i].exp_ce));
    end

    // CHR bank write
    wr(16'h4100, 8'd2);
    wr(16'h4101, 8'd5);
    chr_ain = 14'h1000;
    #1 chk("bank2_chr_aout", 32'(chr_aout_b), 32'h202800);
    wr(16'h4100, 8'd8);
    wr(16'h4101, 8'd6);
    prg_ain = 16'h8123;
    #1 chk("prg_bank_aout", 32'(prg_aout_b), 32'h030123);
    chk("prg_allow_rd", 32'(prg_allow_b), 32'h1);

    // latch=2 with reload: third filtered rise raises irq
    wr(16'h4100, 8'd10); wr(16'h4101, 8'd2);
    wr(16'h4100, 8'd12); wr(16'h4101, 8'd0);
    wr(16'h4100, 8'd11); wr(16'h4101, 8'd1);
    a12_pulse(3, 0); chk("irq_rise1", 32'(irq_b), 32'h0);
    a12_pulse(3, 0); chk("irq_rise2", 32'(irq_b), 32'h0);
    a12_pulse(3, 0); chk("irq_rise3", 32'(irq_b), 32'h1);
    wr(16'h4100, 8'd13); wr(16'h4101, 8'd0);
    chk("irq_ack", 32'(irq_b), 32'h0);

    // filter length with latch=0 (every counted edge fires)
    wr(16'h4100, 8'd10); wr(16'h4101, 8'd0);
    a12_pulse(1, 3); chk("filt_low1", 32'(irq_b), 32'h0);
    a12_pulse(2, 0); chk("filt_low2", 32'(irq_b), 32'h0);
    a12_pulse(3, 0); chk("filt_low3", 32'(irq_b), 32'h1);
    wr(16'h4100, 8'd13); wr(16'h4101, 8'd0);
    chk("filt_ack", 32'(irq_b), 32'h0);
    a12_pulse(4, 0); chk("latch0_again", 32'(irq_b), 32'h1);

    // set wins over same-cycle ack
    wr(16'h4101, 8'd0);
    chk("pre_set_ack", 32'(irq_b), 32'h0);
    chr_ain = 14'h0000; ce = 1'b1;
    repeat (3) tick();
    chr_ain = 14'h1000; prg_ain = 16'h4101; prg_din = 8'h00; prg_write = 1'b1;
    tick();
    prg_write = 1'b0; ce = 1'b0;
    chk("set_beats_ack", 32'(irq_b), 32'h1);
    // set wins over same-cycle disable, then a plain disable clears
    wr(16'h4100, 8'd11);
    chr_ain = 14'h0000; ce = 1'b1;
    repeat (3) tick();
    chr_ain = 14'h1000; prg_ain = 16'h4101; prg_din = 8'h00; prg_write = 1'b1;
    tick();
    prg_write = 1'b0; ce = 1'b0;
    chk("set_beats_dis", 32'(irq_b), 32'h1);
    wr(16'h4101, 8'd0);
    chk("dis_clears", 32'(irq_b), 32'h0);
    check_all();

    // asynchronous reset with irq pending
    wr(16'h4100, 8'd1); wr(16'h4101, 8'd6);
    wr(16'h4100, 8'd9); wr(16'h4101, 8'd1);
    wr(16'h4100, 8'd11); wr(16'h4101, 8'd1);
    a12_pulse(3, 0);
    chk("pre_rst_irq", 32'(irq_b), 32'h1);
    chr_ain = 14'h0800;
    #1 chk("pre_rst_chr", 32'(chr_aout_b), 32'h203000);
    chk("pre_rst_a10", 32'(vram_a10_b), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq_b), 32'h0);
    chk("arst_chr", 32'(chr_aout_b), 32'h200800);
    chk("arst_a10", 32'(vram_a10_b), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized run against the model
    a12_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      prg_read = 1'b0; prg_write = 1'b0;
      flags = $urandom;
      case ($urandom_range(0, 5))
        0: begin prg_ain = 16'h4100; prg_write = 1'b1; prg_din = 8'($urandom_range(0, 15)); end
        1: begin
          prg_ain = 16'h4101; prg_write = 1'b1;
          prg_din = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        end
        2: begin prg_ain = 16'h4100; prg_read = 1'b1; end
        3: begin
          prg_ain = 16'($urandom); prg_din = 8'($urandom);
          prg_write = 1'($urandom_range(0, 1)); prg_read = 1'($urandom_range(0, 1));
        end
        default: prg_ain = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) a12_lvl = ~a12_lvl;
      chr_ain = 14'($urandom_range(0, 16383));
      chr_ain[12] = a12_lvl;
      tick();
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
